tmr_resync_ctrl: RTL and testbench



---
 rtl/croc_pkg.sv | 20 ++
 rtl/tmr_err_counter.sv | 34 +++
 rtl/tmr_resync_ctrl.sv | 147 ++++++++++++++
 tb/tb_tmr_resync_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/croc_pkg.sv
// Shared types and defaults for the TMR recovery sequencer.
package croc_pkg;

    localparam int unsigned NumTmrCores      = 3;
    localparam int unsigned DefSynchTimeout  = 1024;
    localparam int unsigned DefSetbackCycles = 4;
    localparam int unsigned DefCntWidth      = 8;

    typedef enum logic [1:0] {
        IDLE,
        SYNC_REQ,
        SETBACK,
        RESUME
    } tmr_resync_state_e;

    function automatic logic [1:0] popcount3(input logic [NumTmrCores-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/tmr_err_counter.sv
// Saturating per-core error counter; a clear outranks a coincident increment.
module tmr_err_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/tmr_resync_ctrl.sv
// Recovery sequencer for the lock-stepped TMR cores: sync request, common
// setback, release pulse, with per-core error counters and sticky failure.
module tmr_resync_ctrl
    import croc_pkg::*;
#(
    parameter int unsigned SynchTimeout  = DefSynchTimeout,
    parameter int unsigned SetbackCycles = DefSetbackCycles,
    parameter int unsigned CntWidth      = DefCntWidth
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic [NumTmrCores-1:0]          mismatch_i,
    input  logic [NumTmrCores-1:0]          cores_synch_i,
    input  logic                            clr_i,
    output logic                            sw_synch_req_o,
    output logic [NumTmrCores-1:0]          core_setback_o,
    output logic                            resynch_req_o,
    output logic [NumTmrCores-1:0]          fault_core_o,
    output logic                            failure_o,
    output logic                            busy_o,
    output logic [NumTmrCores*CntWidth-1:0] err_cnt_o
);

    // One cycle counter serves both the sync timeout and the setback hold.
    localparam int unsigned CycMax = (SynchTimeout > SetbackCycles) ? SynchTimeout : SetbackCycles;
    localparam int unsigned CycW   = (CycMax > 2) ? $clog2(CycMax) : 1;

    tmr_resync_state_e       state_q, state_d;
    logic [CycW-1:0]         cyc_cnt_q, cyc_cnt_d;
    logic [NumTmrCores-1:0]  fault_q, fault_d;
    logic                    failure_q, failure_d;
    logic                    sw_q, sw_d;
    logic [NumTmrCores-1:0]  setback_q, setback_d;
    logic                    resynch_q, resynch_d;
    logic                    busy_q, busy_d;
    logic [NumTmrCores-1:0]  inc_vec;
    logic                    fail_set;
    logic [1:0]              mm_pop;

    assign mm_pop = popcount3(mismatch_i);

    always_comb begin
        state_d   = state_q;
        cyc_cnt_d = cyc_cnt_q + CycW'(1);
        fault_d   = fault_q;
        fail_set  = 1'b0;
        inc_vec   = '0;

        case (state_q)
            IDLE: begin
                cyc_cnt_d = '0;
                if (enable_i) begin
                    if (mm_pop == 2'd1) begin
                        fault_d = mismatch_i;
                        inc_vec = mismatch_i;
                        state_d = SYNC_REQ;
                    end else if (mm_pop >= 2'd2) begin
                        fail_set = 1'b1;
                    end
                end
            end
            SYNC_REQ: begin
                // The outvoted core's own sync flag is irrelevant; sync beats timeout.
                if (&(cores_synch_i | fault_q)) begin
                    state_d   = SETBACK;
                    cyc_cnt_d = '0;
                end else if (cyc_cnt_q == CycW'(SynchTimeout - 1)) begin
                    state_d   = IDLE;
                    cyc_cnt_d = '0;
                    fail_set  = 1'b1;
                end
            end
            SETBACK: begin
                if (cyc_cnt_q == CycW'(SetbackCycles - 1)) begin
                    state_d   = RESUME;
                    cyc_cnt_d = '0;
                end
            end
            RESUME: begin
                cyc_cnt_d = '0;
                if (cores_synch_i == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                cyc_cnt_d = '0;
            end
        endcase

        if (!enable_i) begin
            state_d   = IDLE;
            cyc_cnt_d = '0;
            fail_set  = 1'b0;
            inc_vec   = '0;
        end

        failure_d = clr_i ? 1'b0 : (failure_q | fail_set);
        sw_d      = (state_d == SYNC_REQ);
        setback_d = {NumTmrCores{state_d == SETBACK}};
        resynch_d = (state_d == RESUME) && (state_q != RESUME);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cyc_cnt_q <= '0;
            fault_q   <= '0;
            failure_q <= 1'b0;
            sw_q      <= 1'b0;
            setback_q <= '0;
            resynch_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            fault_q   <= fault_d;
            failure_q <= failure_d;
            sw_q      <= sw_d;
            setback_q <= setback_d;
            resynch_q <= resynch_d;
            busy_q    <= busy_d;
        end
    end

    assign sw_synch_req_o = sw_q;
    assign core_setback_o = setback_q;
    assign resynch_req_o  = resynch_q;
    assign fault_core_o   = fault_q;
    assign failure_o      = failure_q;
    assign busy_o         = busy_q;

    for (genvar gi = 0; gi < NumTmrCores; gi++) begin : g_err_cnt
        tmr_err_counter #(
            .Width(CntWidth)
        ) u_err_counter (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .clr_i (clr_i),
            .inc_i (inc_vec[gi]),
            .cnt_o (err_cnt_o[gi*CntWidth +: CntWidth])
        );
    end

endmodule

// File: tb/tb_tmr_resync_ctrl.sv
// Directed bench for tmr_resync_ctrl with a cycle-level reference model.
module tb_tmr_resync_ctrl;

    localparam int TO = 16;
    localparam int SB = 4;
    localparam int CW = 2;

    logic         clk = 1'b0;
    logic         rst, en, clr;
    logic [2:0]   mm, sync;
    logic         sw, resynch, fail, busy;
    logic [2:0]   setback, fault;
    logic [3*CW-1:0] err;

    always #5 clk = ~clk;

    tmr_resync_ctrl #(
        .SynchTimeout (TO),
        .SetbackCycles(SB),
        .CntWidth     (CW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .mismatch_i    (mm),
        .cores_synch_i (sync),
        .clr_i         (clr),
        .sw_synch_req_o(sw),
        .core_setback_o(setback),
        .resynch_req_o (resynch),
        .fault_core_o  (fault),
        .failure_o     (fail),
        .busy_o        (busy),
        .err_cnt_o     (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 waiting for sync, 2 setback, 3 release;
    // m_t counts cycles spent in the current mode.
    int         m_mode = 0;
    int         m_t = 0;
    logic [2:0] m_fault = 3'b000;
    logic       m_fail = 1'b0;
    int         m_cnt [3] = '{0, 0, 0};

    always @(posedge clk) begin
        int inc_idx;
        bit fset;
        inc_idx = -1;
        fset    = 0;
        if (rst) begin
            m_mode = 0; m_t = 0; m_fault = 3'b000; m_fail = 1'b0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            if (!en) begin
                m_mode = 0; m_t = 0;
            end else begin
                case (m_mode)
                    0: begin
                        if ($countones(mm) == 1) begin
                            m_fault = mm;
                            for (int i = 0; i < 3; i++) if (mm[i]) inc_idx = i;
                            m_mode = 1; m_t = 0;
                        end else if ($countones(mm) >= 2) begin
                            fset = 1;
                        end
                    end
                    1: begin
                        if ((sync | m_fault) == 3'b111) begin
                            m_mode = 2; m_t = 0;
                        end else if (m_t == TO - 1) begin
                            fset = 1; m_mode = 0; m_t = 0;
                        end else m_t++;
                    end
                    2: begin
                        if (m_t == SB - 1) begin m_mode = 3; m_t = 0; end
                        else m_t++;
                    end
                    default: begin
                        if (sync == 3'b000) begin m_mode = 0; m_t = 0; end
                        else m_t++;
                    end
                endcase
            end
            if (clr) begin
                m_fail = 1'b0;
                for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            end else begin
                if (fset) m_fail = 1'b1;
                if (inc_idx >= 0 && m_cnt[inc_idx] < (1 << CW) - 1) m_cnt[inc_idx]++;
            end
        end
    end

    function automatic logic [3*CW-1:0] model_err();
        logic [3*CW-1:0] v;
        for (int i = 0; i < 3; i++) v[i*CW +: CW] = m_cnt[i][CW-1:0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        chk("model sw_synch_req", 32'(sw), 32'(m_mode == 1));
        chk("model core_setback", 32'(setback), (m_mode == 2) ? 32'h7 : 32'h0);
        chk("model resynch_req", 32'(resynch), 32'(m_mode == 3 && m_t == 0));
        chk("model busy", 32'(busy), 32'(m_mode != 0));
        chk("model fault_core", 32'(fault), 32'(m_fault));
        chk("model failure", 32'(fail), 32'(m_fail));
        chk("model err_cnt", 32'(err), 32'(model_err()));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; mm = 3'b000; sync = 3'b000; clr = 1'b0;
        tick(); tick();
        chk("reset sw", 32'(sw), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset err", 32'(err), 0);
        chk("reset failure", 32'(fail), 0);
        rst = 1'b0; en = 1'b1;
        tick();
        $display("reset released");

        // Single fault on core1, healthy cores sync at t+5
        mm = 3'b010; tick(); mm = 3'b000;
        chk("single sw t+1", 32'(sw), 1);
        chk("single fault", 32'(fault), 32'h2);
        chk("single err", 32'(err), 32'h04);
        tick(); tick(); tick(); tick();
        chk("single sw t+5", 32'(sw), 1);
        sync = 3'b101;
        tick();
        chk("single sw t+6", 32'(sw), 0);
        chk("single setback t+6", 32'(setback), 32'h7);
        tick(); tick(); tick();
        chk("single setback t+9", 32'(setback), 32'h7);
        tick();
        chk("single setback t+10", 32'(setback), 0);
        chk("single resynch t+10", 32'(resynch), 1);
        tick();
        chk("single resynch t+11", 32'(resynch), 0);
        chk("single busy t+11", 32'(busy), 1);
        sync = 3'b000;
        tick();
        chk("single busy end", 32'(busy), 0);
        chk("single err end", 32'(err), 32'h04);
        chk("single failure", 32'(fail), 0);
        $display("single-fault recovery sequence applied");

        // Double fault
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clear err", 32'(err), 0);
        mm = 3'b011; tick(); mm = 3'b000;
        chk("double failure", 32'(fail), 1);
        chk("double busy", 32'(busy), 0);
        chk("double err", 32'(err), 0);
        $display("double-fault event applied");

        // Timeout with no sync
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clear failure", 32'(fail), 0);
        mm = 3'b001; tick(); mm = 3'b000;
        repeat (15) tick();
        chk("timeout sw t+16", 32'(sw), 1);
        chk("timeout failure t+16", 32'(fail), 0);
        tick();
        chk("timeout sw t+17", 32'(sw), 0);
        chk("timeout busy t+17", 32'(busy), 0);
        chk("timeout failure t+17", 32'(fail), 1);
        chk("timeout err", 32'(err), 32'h01);
        $display("sync timeout sequence applied");

        // Masking during SYNC_REQ, then abort in SETBACK
        clr = 1'b1; tick(); clr = 1'b0;
        mm = 3'b010; tick(); mm = 3'b100; tick(); mm = 3'b000;
        chk("mask err", 32'(err), 32'h04);
        chk("mask failure", 32'(fail), 0);
        sync = 3'b101; tick(); sync = 3'b000;
        chk("abort setback before", 32'(setback), 32'h7);
        tick();
        en = 1'b0; tick();
        chk("abort setback", 32'(setback), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort err kept", 32'(err), 32'h04);
        chk("abort fault kept", 32'(fault), 32'h2);
        en = 1'b1; tick();
        chk("abort stays idle", 32'(busy), 0);
        $display("masking and abort applied");

        // Clear coincident with increment
        mm = 3'b100; clr = 1'b1; tick(); mm = 3'b000; clr = 1'b0;
        chk("clr wins err", 32'(err), 0);
        chk("clr seq busy", 32'(busy), 1);
        chk("clr seq fault", 32'(fault), 32'h4);
        en = 1'b0; tick(); en = 1'b1;
        chk("clr seq aborted", 32'(busy), 0);
        $display("clear-vs-increment applied");

        // Saturation on core0 over five full recoveries
        for (int k = 1; k <= 5; k++) begin
            mm = 3'b001; tick(); mm = 3'b000;
            sync = 3'b110; tick(); sync = 3'b000;
            for (int i = 0; i < 20 && busy; i++) tick();
            chk("recovery completes", 32'(busy), 0);
            chk("saturating count", 32'(err[CW-1:0]), (k > 3) ? 32'd3 : 32'(k));
            $display("recovery %0d on core0 applied", k);
        end
        chk("saturated err", 32'(err), 32'h03);

        // Reset mid-sequence
        mm = 3'b010; tick(); mm = 3'b000;
        chk("pre-reset busy", 32'(busy), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid reset busy", 32'(busy), 0);
        chk("mid reset sw", 32'(sw), 0);
        chk("mid reset err", 32'(err), 0);
        chk("mid reset fault", 32'(fault), 0);
        tick();
        $display("mid-sequence reset applied");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
